if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Presents Instruction and PC (fetch address + 4) to the decode stage; decode consumes Instruction and drives hazard/freeze back.
- Honours freeze (stall) and Branch_taken (redirect + flush) from downstream.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_id_reg.sv | 44 ++++
 rtl/if_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
// Holds the PC width, the bubble encoding and the fetch FSM state type.
package if_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] IF_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register (load, hold, flush).
// Ports: clk_i, rst_ni (sync, active-low), load_i, flush_i, hold_i,
//        pc_i/instr_i (next contents), pc_o/instr_o/valid_o (register).
// Priority: reset > flush > hold > load.
module if_id_reg
    import if_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] instr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] instr_o,
    output logic            valid_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] instr_q;
    logic            valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            pc_q    <= '0;
            instr_q <= IF_NOP;
            valid_q <= 1'b0;
        end else if (hold_i) begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, req/ack instruction-memory port and IF/ID register.
// Ports: CLK, RST (sync, active-low), freeze, Branch_taken,
//        Branch_Address, imem_req/imem_addr/imem_ack/imem_rdata,
//        PC/Instruction/valid (IF/ID). Optional macro IF_PERF_CNT_EN
//        adds fetch_count and stall_count outputs.
module if_stage
    import if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            freeze,
    input  logic            Branch_taken,
    input  logic [PC_W-1:0] Branch_Address,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] PC,
    output logic [PC_W-1:0] Instruction,
    output logic            valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);

    if_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [PC_W-1:0] hdata_q, hdata_d;
    logic [PC_W-1:0] haddr_q, haddr_d;
    logic            req_q, req_d;

    logic            ack;
    logic [PC_W-1:0] next_addr;
    logic            ld;
    logic [PC_W-1:0] ld_pc;
    logic [PC_W-1:0] ld_instr;

    // An ack only counts while we actually hold a request
    // (e.g. not in the first cycle after reset).
    assign ack       = imem_ack & req_q;
    assign next_addr = addr_q + PC_STEP;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        hdata_d  = hdata_q;
        haddr_d  = haddr_q;
        ld       = 1'b0;
        ld_pc    = next_addr;
        ld_instr = imem_rdata;

        if (Branch_taken) begin
            pc_d    = Branch_Address;
            hdata_d = IF_NOP;
            haddr_d = '0;
            // The memory must still see the old address until it acks.
            if (req_q && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                addr_d  = Branch_Address;
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack && freeze) begin
                        hdata_d = imem_rdata;
                        haddr_d = addr_q;
                        state_d = HOLD;
                    end else if (ack) begin
                        ld     = 1'b1;
                        pc_d   = next_addr;
                        addr_d = next_addr;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        ld       = 1'b1;
                        ld_pc    = haddr_q + PC_STEP;
                        ld_instr = hdata_q;
                        pc_d     = next_addr;
                        addr_d   = next_addr;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    // pc_q carries the pending branch target.
                    if (ack) begin
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        req_d = (state_d != HOLD);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hdata_q <= IF_NOP;
            haddr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hdata_q <= hdata_d;
            haddr_q <= haddr_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    if_id_reg u_if_id (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .load_i  (ld),
        .flush_i (Branch_taken),
        .hold_i  (freeze),
        .pc_i    (ld_pc),
        .instr_i (ld_instr),
        .pc_o    (PC),
        .instr_o (Instruction),
        .valid_o (valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fcnt_q;
    logic [31:0] scnt_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (ld && !freeze && !Branch_taken) begin
                fcnt_q <= fcnt_q + 32'd1;
            end
            if (freeze || state_q == DRAIN) begin
                scnt_q <= scnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fcnt_q;
    assign stall_count = scnt_q;
`endif

endmodule
